// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: owns the single pixel-write port of the VGA framebuffer
// adapter. It arbitrates two pixel requesters round-robin and runs a
// full-screen clear sequencer that takes the port while it paints.
//
// Handshake: a requester raises valid with stable x/y/c and holds them until
// the cycle where ready is also high; that cycle is the transfer. ready may
// depend combinationally on valid. Only one ready is high in any cycle, and
// no ready is high while clearing or while clear_req is asserted.
module vga_write_arbiter #(
    parameter int              SCREEN_W       = 320,
    parameter int              SCREEN_H       = 240,
    parameter int              X_W            = 9,
    parameter int              Y_W            = 8,
    parameter int              C_W            = 3,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [C_W-1:0]  RESET_COLOUR   = 3'b111
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             clear_req,
    input  logic [C_W-1:0]   clear_colour,
    output logic             clear_busy,
    input  logic             valid0,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [C_W-1:0]   c0,
    output logic             ready0,
    input  logic             valid1,
    input  logic [X_W-1:0]   x1,
    input  logic [Y_W-1:0]   y1,
    input  logic [C_W-1:0]   c1,
    output logic             ready1,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [C_W-1:0]   colour,
    output logic             plot,
    output logic             drop
);

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
    localparam state_t         RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;

    state_t          state;
    state_t          state_next;
    logic            last_grant;
    logic [X_W-1:0]  cx;
    logic [Y_W-1:0]  cy;
    logic [C_W-1:0]  fill;

    logic            take0;
    logic            take1;
    logic [X_W-1:0]  px;
    logic [Y_W-1:0]  py;
    logic [C_W-1:0]  pc;
    logic            in_range;
    logic            last_pixel;

    // The current state is visible to the outside world as clear_busy.
    assign clear_busy = (state == CLEAR);

    // Round-robin grant: on a tie the requester that did not win last goes.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (state == SERVE && !clear_req) begin
            if (valid0 && valid1) begin
                if (last_grant) ready0 = 1'b1;
                else            ready1 = 1'b1;
            end else if (valid0) begin
                ready0 = 1'b1;
            end else if (valid1) begin
                ready1 = 1'b1;
            end
        end
    end

    // Select the transferring pixel and classify it against the screen bounds.
    always_comb begin
        take0      = valid0 & ready0;
        take1      = valid1 & ready1;
        px         = take1 ? x1 : x0;
        py         = take1 ? y1 : y0;
        pc         = take1 ? c1 : c0;
        in_range   = (px <= X_LAST) && (py <= Y_LAST);
        last_pixel = (cx == X_LAST) && (cy == Y_LAST);
    end

    // Next-state: a clear request starts a clear; the final pixel ends it.
    always_comb begin
        state_next = state;
        case (state)
            SERVE: if (clear_req)  state_next = CLEAR;
            CLEAR: if (last_pixel) state_next = SERVE;
            default: state_next = SERVE;
        endcase
    end

    // State register; a reset always restarts according to CLEAR_ON_RESET.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_next;
    end

    // Registered adapter port, clear counters, fill colour and grant history.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            plot       <= 1'b0;
            drop       <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            last_grant <= 1'b1;
            cx         <= '0;
            cy         <= '0;
            fill       <= RESET_COLOUR;
        end else begin
            plot <= 1'b0;
            drop <= 1'b0;
            if (state == CLEAR) begin
                // Raster sweep; clear_req is deliberately ignored here.
                plot   <= 1'b1;
                x      <= cx;
                y      <= cy;
                colour <= fill;
                if (cx == X_LAST) begin
                    cx <= '0;
                    if (cy == Y_LAST) cy <= '0;
                    else              cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end else if (clear_req) begin
                fill <= clear_colour;
                cx   <= '0;
                cy   <= '0;
            end else if (take0 || take1) begin
                last_grant <= take1;
                if (in_range) begin
                    plot   <= 1'b1;
                    x      <= px;
                    y      <= py;
                    colour <= pc;
                end else begin
                    // Accept and discard so the requester keeps moving.
                    drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Owns the single pixel-write port of the 320x240 VGA framebuffer adapter (x, y, colour, plot).
- Shares that port between two pixel requesters using per-pixel valid/ready with round-robin arbitration:
  - requester 0: the HTML parser's glyph/text writer.
  - requester 1: the box/rule fill engine.
- Contains a screen-clear sequencer that paints every pixel one colour, on reset and on request.
- Gives back-pressure so the parser can pause the HTML reader stream.

Parameters:
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- C_W, 3, colour width (1 bit per channel, R G B).
- CLEAR_ON_RESET, 1, when 1 a full clear starts immediately after reset.
- RESET_COLOUR, 3'b111, colour of the reset-triggered clear (white).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_req  in  1  one-cycle pulse; starts a screen clear.
- clear_colour  in  C_W  fill colour, sampled on the clear_req cycle.
- clear_busy  out  1  high while the clear sequencer owns the port.
- valid0 / x0 / y0 / c0  in  1 / X_W / Y_W / C_W  requester 0 pixel.
- ready0  out  1  requester 0 pixel accepted this cycle when valid0 is also high.
- valid1 / x1 / y1 / c1  in  1 / X_W / Y_W / C_W  requester 1 pixel.
- ready1  out  1  requester 1 pixel accepted this cycle when valid1 is also high.
- x  out  X_W  adapter x, registered.
- y  out  Y_W  adapter y, registered.
- colour  out  C_W  adapter colour, registered.
- plot  out  1  adapter write enable, registered, one pulse per pixel.
- drop  out  1  one-cycle pulse: an accepted pixel was out of range and discarded.

Behaviour:
- States: SERVE and CLEAR. clear_busy = (state==CLEAR), combinational.
- Reset, with reset high at a clock edge:
  - plot=0, x=0, y=0, colour=0, drop=0, last_grant=1 (so requester 0 wins the first tie).
  - Clear counters cx=0, cy=0.
  - state=CLEAR with fill colour RESET_COLOUR if CLEAR_ON_RESET=1, otherwise SERVE.
  - A reset during a clear restarts it from (0,0).
- SERVE arbitration, combinational within the cycle:
  - If clear_req=1, ready0=ready1=0.
  - Otherwise, if exactly one valid is high, that requester gets ready.
  - If both are high, the requester other than last_grant gets ready.
  - At most one ready is high per cycle. ready is never high in CLEAR.
- Transfer = valid&ready, and last_grant updates to that requester.
- Requester rule: once valid is high, it and its x/y/c stay stable until the transfer.
- Latency: an in-range pixel accepted at edge N gives plot=1 with that x/y/colour in the cycle after edge N.
  - plot returns to 0 on the next cycle unless another transfer occurs.
  - Full throughput is 1 pixel per clock.
- Out-of-range pixel (x>=SCREEN_W or y>=SCREEN_H):
  - It is still accepted, so the requester is not stalled.
  - plot stays 0, drop=1 for one cycle, and x/y/colour hold their previous values.
- clear_req in SERVE:
  - Latches clear_colour and sets cx=0, cy=0, then moves to CLEAR on the next edge.
  - A pending valid on the same cycle is not accepted and waits.
- CLEAR, each cycle:
  - plot=1, x=cx, y=cy, colour=fill colour (registered, visible the next cycle).
  - Then cx++. When cx==SCREEN_W-1, cx wraps to 0 and cy++.
  - Issuing (SCREEN_W-1, SCREEN_H-1) returns the state to SERVE.
  - Total: exactly SCREEN_W*SCREEN_H = 76800 plot pulses, in raster order, with no gaps.
- clear_req while in CLEAR is ignored, with no restart and no colour change.
- Counters are sized X_W/Y_W. Values never exceed SCREEN_W-1 / SCREEN_H-1, so no modular wrap occurs.

Test Plan:
- Reset, CLEAR_ON_RESET=1:
  - plot pulses 76800 consecutive cycles, first (0,0) and last (319,239), colour 3'b111.
  - clear_busy is high for exactly 76800 cycles and ready0/ready1 stay 0 throughout.
  - Afterwards, valid0 with (5,7,3'b100) gives plot=1 at (5,7,3'b100) one cycle after the transfer.
- valid0 and valid1 held high with 4 pixels each:
  - Grants alternate 0,1,0,1,... and plot is high 8 consecutive cycles with no lost or duplicated pixels.
  - A backlogged requester never waits more than 1 cycle.
- valid1 with (320,10) then (10,240):
  - Both are accepted, drop pulses twice, and plot stays 0.
  - A following (319,239,3'b001) plots normally.
- clear_req with clear_colour=3'b010 on the same cycle as valid0:
  - ready0=0 that cycle; the clear of 76800 pixels in colour 3'b010 runs.
  - The held pixel transfers on the first SERVE cycle.
- Mid-clear disturbances:
  - A clear_req at pixel 1000 of a clear is ignored; the total stays 76800 and the colour is unchanged.
  - A reset asserted at pixel 5000 makes the next plot (0,0) with colour RESET_COLOUR.
- CLEAR_ON_RESET=0: after reset, clear_busy=0, plot=0, and requester traffic is served immediately.
